// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the execute-stage multiply/divide unit.
// Holds the 4-bit op encodings and the helpers that decide whether an op
// launches a multi-cycle operation and which latency class it belongs to.
// Configuration: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU as startable ops;
// when undefined, ops 9-12 behave as NONE.
package mdu_pkg;

  localparam int unsigned MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_OP_NONE  = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MFHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MFLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTLO  = 4'd8;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MADD  = 4'd9;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MADDU = 4'd10;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MSUB  = 4'd11;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MSUBU = 4'd12;

  // True for ops that occupy the unit for MULT_CYCLES.
  function automatic logic is_mult_class(input logic [MDU_OP_W-1:0] op);
    logic r;
    r = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_OP_MADD) || (op == MDU_OP_MADDU) ||
             (op == MDU_OP_MSUB) || (op == MDU_OP_MSUBU);
`endif
    return r;
  endfunction

  // True for ops that start a multi-cycle operation when start is pulsed.
  function automatic logic is_mdu_start(input logic [MDU_OP_W-1:0] op);
    return is_mult_class(op) || (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_stage_e_if.sv
// mdu_stage_e_if: E-stage request/response bundle for the multiply/divide unit.
//   start   - one-cycle launch pulse
//   mdu_op  - operation code (mdu_pkg encodings)
//   rs_val  - operand A (forwarded)
//   rt_val  - operand B (forwarded)
//   busy    - operation in flight (feeds D-stage stall)
//   hi, lo  - architectural HI/LO
//   mdu_out - mfhi/mflo read value, combinational from mdu_op
// master: pipeline side; slave: the unit.
interface mdu_stage_e_if;
  import mdu_pkg::*;

  logic                start;
  logic [MDU_OP_W-1:0] mdu_op;
  logic [31:0]         rs_val;
  logic [31:0]         rt_val;
  logic                busy;
  logic [31:0]         hi;
  logic [31:0]         lo;
  logic [31:0]         mdu_out;

  modport master (
    output start, mdu_op, rs_val, rt_val,
    input  busy, hi, lo, mdu_out
  );

  modport slave (
    input  start, mdu_op, rs_val, rt_val,
    output busy, hi, lo, mdu_out
  );
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational 64-bit result generator.
//   i_op      - operation code
//   i_rs/i_rt - operands
//   i_hi/i_lo - current HI/LO accumulator (only with MDU_MADD_EN)
//   o_res     - {hi,lo} result
//   o_wr      - result should be written to HI/LO (low for divide by zero
//               and for non-arithmetic ops)
// Configuration: MDU_MADD_EN enables the accumulate adder.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] i_op,
  input  logic [31:0]         i_rs,
  input  logic [31:0]         i_rt,
`ifdef MDU_MADD_EN
  input  logic [31:0]         i_hi,
  input  logic [31:0]         i_lo,
`endif
  output logic [63:0]         o_res,
  output logic                o_wr
);

  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic [63:0]        w_sprod;
  logic [63:0]        w_uprod;

  assign w_sa    = i_rs;
  assign w_sb    = i_rt;
  assign w_sprod = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign w_uprod = {32'd0, i_rs} * {32'd0, i_rt};

`ifdef MDU_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = {i_hi, i_lo};
`endif

  always_comb begin
    o_res = '0;
    o_wr  = 1'b0;
    case (i_op)
      MDU_OP_MULT: begin
        o_res = w_sprod;
        o_wr  = 1'b1;
      end
      MDU_OP_MULTU: begin
        o_res = w_uprod;
        o_wr  = 1'b1;
      end
      MDU_OP_DIV: begin
        if (i_rt != '0) begin
          o_wr = 1'b1;
          // Most-negative / -1 overflows the quotient; pin it explicitly.
          if (i_rs == 32'h8000_0000 && i_rt == '1)
            o_res = {32'd0, 32'h8000_0000};
          else
            o_res = {w_sa % w_sb, w_sa / w_sb};
        end
      end
      MDU_OP_DIVU: begin
        if (i_rt != '0) begin
          o_wr  = 1'b1;
          o_res = {i_rs % i_rt, i_rs / i_rt};
        end
      end
`ifdef MDU_MADD_EN
      MDU_OP_MADD: begin
        o_res = w_acc + w_sprod;
        o_wr  = 1'b1;
      end
      MDU_OP_MADDU: begin
        o_res = w_acc + w_uprod;
        o_wr  = 1'b1;
      end
      MDU_OP_MSUB: begin
        o_res = w_acc - w_sprod;
        o_wr  = 1'b1;
      end
      MDU_OP_MSUBU: begin
        o_res = w_acc - w_uprod;
        o_wr  = 1'b1;
      end
`endif
      default: begin
        o_res = '0;
        o_wr  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_stage_e.sv
// mdu_stage_e: execute-stage multiply/divide unit with HI/LO registers.
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   mdu    - slave side of mdu_stage_e_if (start/op/operands in,
//            busy/hi/lo/mdu_out out)
// The result is computed at the start edge and held pending; a busy counter
// models the latency and HI/LO are written on the edge it reaches zero.
// Configuration: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_stage_e
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  mdu_stage_e_if.slave mdu
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_ph;
  logic [31:0]      r_pl;
  logic             r_pwr;

  logic             w_busy;
  logic             w_accept;
  logic [CNT_W-1:0] w_lat;
  logic [63:0]      w_res;
  logic             w_res_wr;

  mdu_arith u_arith (
    .i_op  (mdu.mdu_op),
    .i_rs  (mdu.rs_val),
    .i_rt  (mdu.rt_val),
`ifdef MDU_MADD_EN
    .i_hi  (r_hi),
    .i_lo  (r_lo),
`endif
    .o_res (w_res),
    .o_wr  (w_res_wr)
  );

  assign w_busy   = (r_cnt != '0);
  assign w_accept = mdu.start && !w_busy && is_mdu_start(mdu.mdu_op);

  always_comb begin
    w_lat = CNT_W'(DIV_CYCLES);
    if (is_mult_class(mdu.mdu_op))
      w_lat = CNT_W'(MULT_CYCLES);
  end

  // Operands are consumed at the start edge: only the result (and whether
  // it may be written) is kept, which is all the write-back needs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_ph  <= '0;
      r_pl  <= '0;
      r_pwr <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= w_lat;
      r_ph  <= w_res[63:32];
      r_pl  <= w_res[31:0];
      r_pwr <= w_res_wr;
    end else if (w_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1) && r_pwr) begin
        r_hi <= r_ph;
        r_lo <= r_pl;
      end
    end else if (!mdu.start) begin
      if (mdu.mdu_op == MDU_OP_MTHI) r_hi <= mdu.rs_val;
      if (mdu.mdu_op == MDU_OP_MTLO) r_lo <= mdu.rs_val;
    end
  end

  always_comb begin
    mdu.mdu_out = '0;
    if (mdu.mdu_op == MDU_OP_MFHI) mdu.mdu_out = r_hi;
    if (mdu.mdu_op == MDU_OP_MFLO) mdu.mdu_out = r_lo;
  end

  assign mdu.busy = w_busy;
  assign mdu.hi   = r_hi;
  assign mdu.lo   = r_lo;

  // The hazard unit must never launch while an operation is in flight.
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (reset) !(mdu.start && w_busy)
  );

endmodule

// File: tb/tb_mdu_stage_e.sv
module tb_mdu_stage_e;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  mdu_stage_e_if bus ();

  mdu_stage_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    bus.mdu_op = op;
    bus.rs_val = v;
    step();
    bus.mdu_op = MDU_OP_NONE;
  endtask

  // Launch an op, present an MTHI during busy (must be ignored), then count
  // busy cycles with a bound and check the final HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int unsigned cnt;
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.rs_val = a;
    bus.rt_val = b;
    step();
    bus.start  = 1'b0;
    bus.mdu_op = MDU_OP_MTHI;
    bus.rs_val = 32'hDEAD_BEEF;
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      step();
    end
    bus.mdu_op = MDU_OP_NONE;
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'(exp_cyc));
    chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.mdu_op = MDU_OP_NONE;
    bus.rs_val = '0;
    bus.rt_val = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);

    mt(MDU_OP_MTHI, 32'h11);
    mt(MDU_OP_MTLO, 32'h22);
    chk("mthi", 64'(bus.hi), 64'h11);
    chk("mtlo", 64'(bus.lo), 64'h22);
    bus.mdu_op = MDU_OP_MFHI; #1;
    chk("mfhi_out", 64'(bus.mdu_out), 64'h11);
    bus.mdu_op = MDU_OP_MFLO; #1;
    chk("mflo_out", 64'(bus.mdu_out), 64'h22);
    bus.mdu_op = MDU_OP_NONE; #1;
    chk("none_out", 64'(bus.mdu_out), 64'h0);

    // MULT: check HI untouched one cycle into the operation
    bus.start = 1'b1; bus.mdu_op = MDU_OP_MULT;
    bus.rs_val = 32'hFFFF_FFFE; bus.rt_val = 32'd3;
    step();
    bus.start = 1'b0; bus.mdu_op = MDU_OP_NONE;
    chk("mult_hi_mid", 64'(bus.hi), 64'h11);
    chk("mult_busy_mid", 64'(bus.busy), 64'd1);
    repeat (4) step();
    chk("mult_busy_last", 64'(bus.busy), 64'd1);
    step();
    chk("mult_busy_done", 64'(bus.busy), 64'd0);
    chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);
    bus.mdu_op = MDU_OP_MFLO; #1;
    chk("mult_mflo_out", 64'(bus.mdu_out), 64'hFFFF_FFFA);
    bus.mdu_op = MDU_OP_NONE;

    run_op("multu", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h1, 32'hFFFF_FFFE);
    run_op("div", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    run_op("divu", MDU_OP_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    mt(MDU_OP_MTHI, 32'h11);
    mt(MDU_OP_MTLO, 32'h22);
    run_op("div0", MDU_OP_DIV, 32'd1234, 32'd0, 10, 32'h11, 32'h22);

    // start with a non-arithmetic op is ignored
    bus.start = 1'b1; bus.mdu_op = MDU_OP_MFLO; bus.rs_val = 32'h55;
    step();
    bus.start = 1'b0; bus.mdu_op = MDU_OP_NONE;
    chk("bad_start_busy", 64'(bus.busy), 64'd0);
    chk("bad_start_hi", 64'(bus.hi), 64'h11);

    mt(MDU_OP_MTHI, 32'h0);
    mt(MDU_OP_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", MDU_OP_MADDU, 32'd1, 32'd1, 5, 32'h1, 32'h0);
    run_op("msub", MDU_OP_MSUB, 32'd2, 32'd3, 5, 32'h0, 32'hFFFF_FFFA);
`else
    bus.start = 1'b1; bus.mdu_op = MDU_OP_MADDU; bus.rs_val = 32'd1; bus.rt_val = 32'd1;
    step();
    bus.start = 1'b0; bus.mdu_op = MDU_OP_NONE;
    chk("op10_busy", 64'(bus.busy), 64'd0);
    repeat (6) step();
    chk("op10_hi", 64'(bus.hi), 64'h0);
    chk("op10_lo", 64'(bus.lo), 64'hFFFF_FFFF);
`endif

    // reset during cycle 3 of a DIV aborts it
    mt(MDU_OP_MTHI, 32'h5);
    bus.start = 1'b1; bus.mdu_op = MDU_OP_DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
    step();
    bus.start = 1'b0; bus.mdu_op = MDU_OP_NONE;
    step();
    step();
    chk("rdiv_busy_pre", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rdiv_busy", 64'(bus.busy), 64'd0);
    chk("rdiv_hi", 64'(bus.hi), 64'h0);
    chk("rdiv_lo", 64'(bus.lo), 64'h0);
    repeat (12) step();
    chk("rdiv_late_hi", 64'(bus.hi), 64'h0);
    chk("rdiv_late_lo", 64'(bus.lo), 64'h0);
    chk("rdiv_late_busy", 64'(bus.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_stage_e.md
Name: mdu_stage_e

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Accepts a one-cycle start with op and operands from the E-stage forwarding muxes.
- Models multi-cycle latency with a busy counter that drives the D-stage stall logic.
- Provides the mfhi/mflo read value that the E/M pipeline register captures as MDUOutE.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); must be ≥1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≥1.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: E-stage instruction is mult/multu/div/divu (or madd family).
- mdu_op  input  4  operation code, encodings in package.
- rs_val  input  32  operand A, forwarded E-stage value.
- rt_val  input  32  operand B, forwarded E-stage value.
- busy  output  1  high while an operation is in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.
- mdu_out  output  32  mfhi→hi, mflo→lo, else 0; combinational from mdu_op.

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, pending result=0. Reset mid-operation aborts it; no HI/LO write.
- Op encodings: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
- Start, sampled at edge T when start=1 and busy=0:
  - operands are latched;
  - the 64-bit result is computed into pending {ph,pl};
  - the counter is loaded with MULT_CYCLES or DIV_CYCLES.
- busy = (counter != 0).
  - busy is high for exactly N cycles after edge T.
  - The counter decrements each edge while nonzero.
- Write-back: on the edge where the counter goes 1→0, hi←ph and lo←pl. New values are visible the first cycle busy=0.
- start with busy=1: ignored. The hazard unit guarantees this does not occur; the verification assertion flags it.
- start with a non-mult/div mdu_op: ignored.
- MTHI/MTLO (start=0, busy=0): hi or lo ← rs_val at the edge. Ignored while busy=1.
- MULT: signed 32×32→64, {hi,lo}. MULTU: unsigned.
- DIV/DIVU: lo=quotient, hi=remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: busy runs its full DIV_CYCLES; hi/lo are left unchanged at completion.
- mdu_out is valid in the same cycle as mdu_op and reflects hi/lo as currently registered. The stall logic prevents mfhi/mflo from reaching E while busy.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: adds ops 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU.
  - Pending result = {hi,lo} ± product, signed or unsigned per op, modulo 2^64.
  - {hi,lo} is sampled at the start edge; latency is MULT_CYCLES.
- Undefined: ops 9–12 behave as NONE; no accumulate adder is synthesized.

Decomposition:
- Shared package mdu_pkg:
  - MDU_OP_* 4-bit constants;
  - MDU_OP_W=4;
  - is_mdu_start(op) helper, shared with the controller and hazard unit.
- One sub-module mdu_arith: purely combinational 64-bit result generation (mult/div/madd, special cases).
- mdu_stage_e holds the counter, pending registers and HI/LO.

Test Plan:
- MULT: rs=0xFFFFFFFE (−2), rt=3, start at T → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU: rs=0xFFFFFFFF, rt=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV: rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV by zero after MTHI 0x11 / MTLO 0x22 → busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- Reset at cycle 3 of a DIV (prior hi=5) → next cycle busy=0, hi=lo=0; counter clear, no late write.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU rs=1, rt=1 → hi=1, lo=0. Without the macro, op 10 → no busy, hi/lo unchanged.
